// File: rtl/cp0_regfile_if.sv
// -----------------------------------------------------------------------------
// cp0_regfile_if
//   Bundle of every non-clock signal of the CP0 register file.
//   master : pipeline side (WB commit, exception unit, interrupt lines).
//            It drives the requests and samples the register outputs.
//   slave  : the cp0_regfile itself.
//
//   Signals:
//     wb_cp0_write_en/addr/data  MTC0 commit from WB
//     cp0_read_addr/_data_o      raw combinational read port
//     int_i[5:0]                 level-sensitive hardware interrupts
//     exc_valid/code/epc/bd      exception entry
//     exc_badvaddr_en/badvaddr   BadVAddr load on exception entry
//     eret_valid                 ERET commit
//     cp0_*_o, int_req_o         current register values, interrupt request
//
//   Handshake: none of these signals has a handshake. Every strobe
//   (wb_cp0_write_en, exc_valid, eret_valid) is a single-cycle command that
//   is sampled on the rising clock edge and always accepted. There is no
//   ready or back-pressure signal.
// -----------------------------------------------------------------------------
interface cp0_regfile_if;
    logic        wb_cp0_write_en;
    logic [4:0]  wb_cp0_write_addr;
    logic [31:0] wb_cp0_write_data;
    logic [4:0]  cp0_read_addr;
    logic [31:0] cp0_read_data_o;
    logic [5:0]  int_i;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        exc_badvaddr_en;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic [31:0] cp0_count_o;
    logic [31:0] cp0_status_o;
    logic [31:0] cp0_cause_o;
    logic [31:0] cp0_epc_o;
    logic [31:0] cp0_config0_o;
    logic        int_req_o;

    modport master (
        output wb_cp0_write_en, wb_cp0_write_addr, wb_cp0_write_data,
        output cp0_read_addr, int_i,
        output exc_valid, exc_code, exc_epc, exc_bd, exc_badvaddr_en, exc_badvaddr,
        output eret_valid,
        input  cp0_read_data_o, cp0_count_o, cp0_status_o, cp0_cause_o,
        input  cp0_epc_o, cp0_config0_o, int_req_o
    );

    modport slave (
        input  wb_cp0_write_en, wb_cp0_write_addr, wb_cp0_write_data,
        input  cp0_read_addr, int_i,
        input  exc_valid, exc_code, exc_epc, exc_bd, exc_badvaddr_en, exc_badvaddr,
        input  eret_valid,
        output cp0_read_data_o, cp0_count_o, cp0_status_o, cp0_cause_o,
        output cp0_epc_o, cp0_config0_o, int_req_o
    );
endinterface

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile
//   Architectural CP0 register file and the write-side owner of CP0 state.
//   It accepts MTC0 commits, exception entry, ERET and six interrupt lines.
//   It runs the Count/Compare timer and presents the raw register values
//   together with a registered interrupt request.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    cp0_regfile_if.slave (see interface header for signal list)
//
//   Implemented registers:
//     8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC,
//     16 Config0. Every other number reads 0 and ignores writes.
//
//   Optional feature (macro CP0_COUNT_HALF_RATE_EN):
//     When defined, Count advances only on every second cycle, paced by a
//     phase bit. An MTC0 to Count clears that phase bit.
// -----------------------------------------------------------------------------
module cp0_regfile #(
    parameter logic [31:0] CONFIG0_VAL = 32'h8000_0082,
    parameter logic [31:0] STATUS_RST  = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    cp0_regfile_if.slave bus
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_CONFIG0  = 5'd16;

    // MTC0 may only change the Status bits IM[15:8], EXL[1] and IE[0].
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic        cause_bd_q;
    logic        cause_ti_q;
    logic [5:0]  cause_ip_hw_q;
    logic [1:0]  cause_ip_sw_q;
    logic [4:0]  cause_exc_q;
    logic        int_req_q;
`ifdef CP0_COUNT_HALF_RATE_EN
    logic        phase_q;
`endif

    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic [31:0] cause_val;
    logic        timer_match;

    assign wr_count   = bus.wb_cp0_write_en && (bus.wb_cp0_write_addr == REG_COUNT);
    assign wr_compare = bus.wb_cp0_write_en && (bus.wb_cp0_write_addr == REG_COMPARE);
    assign wr_status  = bus.wb_cp0_write_en && (bus.wb_cp0_write_addr == REG_STATUS);
    assign wr_cause   = bus.wb_cp0_write_en && (bus.wb_cp0_write_addr == REG_CAUSE);
    assign wr_epc     = bus.wb_cp0_write_en && (bus.wb_cp0_write_addr == REG_EPC);

    assign timer_match = (count_q == compare_q);

    // The timer interrupt is folded into IP[7] at the output. This way IP[15]
    // follows TI in the same cycle that TI sets or clears.
    assign cause_val = {cause_bd_q, cause_ti_q, 14'd0,
                        cause_ip_hw_q[5] | cause_ti_q, cause_ip_hw_q[4:0],
                        cause_ip_sw_q, 1'b0, cause_exc_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            compare_q     <= '0;
            status_q      <= STATUS_RST;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            cause_bd_q    <= 1'b0;
            cause_ti_q    <= 1'b0;
            cause_ip_hw_q <= '0;
            cause_ip_sw_q <= '0;
            cause_exc_q   <= '0;
            int_req_q     <= 1'b0;
`ifdef CP0_COUNT_HALF_RATE_EN
            phase_q       <= 1'b0;
`endif
        end else begin
            // Timer. Exceptions never touch Count or Compare, so these
            // writes proceed whatever else happens in the same cycle.
`ifdef CP0_COUNT_HALF_RATE_EN
            if (wr_count) begin
                count_q <= bus.wb_cp0_write_data;
                phase_q <= 1'b0;
            end else begin
                phase_q <= ~phase_q;
                if (phase_q) count_q <= count_q + 32'd1;
            end
`else
            if (wr_count) count_q <= bus.wb_cp0_write_data;
            else          count_q <= count_q + 32'd1;
`endif
            if (wr_compare) compare_q <= bus.wb_cp0_write_data;

            // A Compare write clears TI, and it wins over a match in the
            // same cycle. The match uses the pre-update Count and Compare.
            if (wr_compare)       cause_ti_q <= 1'b0;
            else if (timer_match) cause_ti_q <= 1'b1;

            cause_ip_hw_q <= bus.int_i;

            int_req_q <= status_q[0] & ~status_q[1]
                       & (|(cause_val[15:8] & status_q[15:8]));

            // Exception entry wins over ERET, and ERET wins over an MTC0 to
            // Status, Cause or EPC.
            if (bus.exc_valid) begin
                cause_exc_q <= bus.exc_code;
                if (!status_q[1]) begin
                    epc_q      <= bus.exc_epc;
                    cause_bd_q <= bus.exc_bd;
                end
                status_q[1] <= 1'b1;
                if (bus.exc_badvaddr_en) badvaddr_q <= bus.exc_badvaddr;
            end else if (bus.eret_valid) begin
                status_q[1] <= 1'b0;
            end else begin
                if (wr_status)
                    status_q <= (status_q & ~STATUS_WMASK)
                              | (bus.wb_cp0_write_data & STATUS_WMASK);
                if (wr_cause) cause_ip_sw_q <= bus.wb_cp0_write_data[9:8];
                if (wr_epc)   epc_q <= bus.wb_cp0_write_data;
            end
        end
    end

    always_comb begin
        bus.cp0_read_data_o = '0;
        case (bus.cp0_read_addr)
            REG_BADVADDR: bus.cp0_read_data_o = badvaddr_q;
            REG_COUNT:    bus.cp0_read_data_o = count_q;
            REG_COMPARE:  bus.cp0_read_data_o = compare_q;
            REG_STATUS:   bus.cp0_read_data_o = status_q;
            REG_CAUSE:    bus.cp0_read_data_o = cause_val;
            REG_EPC:      bus.cp0_read_data_o = epc_q;
            REG_CONFIG0:  bus.cp0_read_data_o = CONFIG0_VAL;
            default:      bus.cp0_read_data_o = '0;
        endcase
    end

    assign bus.cp0_count_o   = count_q;
    assign bus.cp0_status_o  = status_q;
    assign bus.cp0_cause_o   = cause_val;
    assign bus.cp0_epc_o     = epc_q;
    assign bus.cp0_config0_o = CONFIG0_VAL;
    assign bus.int_req_o     = int_req_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// -----------------------------------------------------------------------------
// tb_cp0_regfile
//   Directed bench for cp0_regfile. Expected values are pushed to exp_q when
//   the stimulus is driven. They are popped and compared once the DUT output
//   has settled, one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cp0_regfile;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cp0_regfile_if bus ();

    cp0_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.wb_cp0_write_en   = 1'b1;
        bus.wb_cp0_write_addr = a;
        bus.wb_cp0_write_data = d;
        tick();
        bus.wb_cp0_write_en   = 1'b0;
    endtask

    task automatic set_exc(input logic [4:0] code, input logic [31:0] epc,
                           input logic bd, input logic bv_en, input logic [31:0] bv);
        bus.exc_valid       = 1'b1;
        bus.exc_code        = code;
        bus.exc_epc         = epc;
        bus.exc_bd          = bd;
        bus.exc_badvaddr_en = bv_en;
        bus.exc_badvaddr    = bv;
    endtask

    task automatic clr_exc();
        bus.exc_valid       = 1'b0;
        bus.exc_badvaddr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        bus.cp0_read_addr = a;
        #1;
        d = bus.cp0_read_data_o;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd;

    initial begin
        rst_n                 = 1'b0;
        bus.wb_cp0_write_en   = 1'b0;
        bus.wb_cp0_write_addr = '0;
        bus.wb_cp0_write_data = '0;
        bus.cp0_read_addr     = '0;
        bus.int_i             = '0;
        bus.exc_valid         = 1'b0;
        bus.exc_code          = '0;
        bus.exc_epc           = '0;
        bus.exc_bd            = 1'b0;
        bus.exc_badvaddr_en   = 1'b0;
        bus.exc_badvaddr      = '0;
        bus.eret_valid        = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        expect_v(32'h0040_0000); check("rst_status", bus.cp0_status_o);
        expect_v(32'h0);         check("rst_count", bus.cp0_count_o);
        expect_v(32'h0);         check("rst_cause", bus.cp0_cause_o);
        expect_v(32'h0);         check("rst_epc", bus.cp0_epc_o);
        expect_v(32'h0);         check("rst_int_req", {31'd0, bus.int_req_o});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`ifdef CP0_COUNT_HALF_RATE_EN
        expect_v(32'd0);
`else
        expect_v(32'd1);
`endif
        check("count_first_edge", bus.cp0_count_o);
        expect_v(32'h8000_0082); check("config0", bus.cp0_config0_o);

        // Count/Compare timer and interrupt
        expect_v(32'h0040_8001);
        mtc0(5'd12, 32'h0000_8001);
        check("status_im7_ie", bus.cp0_status_o);
        mtc0(5'd11, 32'd5);
        expect_v(32'd0);
        mtc0(5'd9, 32'd0);
        check("count_load0", bus.cp0_count_o);
`ifdef CP0_COUNT_HALF_RATE_EN
        repeat (10) tick();
        expect_v(32'd5); check("count_at5", bus.cp0_count_o);
        expect_v(32'd0); check("ti_before_match", {31'd0, bus.cp0_cause_o[30]});
        tick();
        expect_v(32'd1); check("ti_set", {31'd0, bus.cp0_cause_o[30]});
        expect_v(32'd1); check("ip7_set", {31'd0, bus.cp0_cause_o[15]});
        expect_v(32'd0); check("int_req_lat", {31'd0, bus.int_req_o});
        tick();
        expect_v(32'd1); check("int_req_on", {31'd0, bus.int_req_o});
`else
        repeat (5) tick();
        expect_v(32'd5); check("count_at5", bus.cp0_count_o);
        expect_v(32'd0); check("ti_before_match", {31'd0, bus.cp0_cause_o[30]});
        tick();
        expect_v(32'd6); check("count_at6", bus.cp0_count_o);
        expect_v(32'd1); check("ti_set", {31'd0, bus.cp0_cause_o[30]});
        expect_v(32'd1); check("ip7_set", {31'd0, bus.cp0_cause_o[15]});
        expect_v(32'd0); check("int_req_lat", {31'd0, bus.int_req_o});
        tick();
        expect_v(32'd1); check("int_req_on", {31'd0, bus.int_req_o});
`endif
        expect_v(32'd0);
        expect_v(32'd0);
        expect_v(32'd1);
        mtc0(5'd11, 32'd100);
        check("ti_cleared", {31'd0, bus.cp0_cause_o[30]});
        check("ip7_cleared", {31'd0, bus.cp0_cause_o[15]});
        check("int_req_still_reg", {31'd0, bus.int_req_o});
        tick();
        expect_v(32'd0); check("int_req_off", {31'd0, bus.int_req_o});
        read_reg(5'd11, rd);
        expect_v(32'd100); check("rd_compare", rd);

        expect_v(32'h0040_0000);
        mtc0(5'd12, 32'h0);
        check("status_clear", bus.cp0_status_o);

        // Exception entry
        set_exc(5'h04, 32'hBFC0_0100, 1'b1, 1'b1, 32'h0000_0003);
        expect_v(32'hBFC0_0100);
        expect_v(32'h8000_0010);
        expect_v(32'h0040_0002);
        tick();
        clr_exc();
        check("exc1_epc", bus.cp0_epc_o);
        check("exc1_cause", bus.cp0_cause_o);
        check("exc1_status", bus.cp0_status_o);
        read_reg(5'd8, rd);
        expect_v(32'h3); check("exc1_badvaddr", rd);

        // Nested exception with EXL already set
        set_exc(5'h05, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
        expect_v(32'hBFC0_0100);
        expect_v(32'h8000_0014);
        tick();
        clr_exc();
        check("exc2_epc_hold", bus.cp0_epc_o);
        check("exc2_cause", bus.cp0_cause_o);

        // ERET
        bus.eret_valid = 1'b1;
        expect_v(32'h0040_0000);
        tick();
        bus.eret_valid = 1'b0;
        check("eret_status", bus.cp0_status_o);

        // Exception against an MTC0 Status in the same cycle
        expect_v(32'h0040_FF00);
        mtc0(5'd12, 32'h0000_FF00);
        check("status_im_all", bus.cp0_status_o);
        set_exc(5'h00, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
        expect_v(32'h0040_FF02);
        expect_v(32'h0000_0400);
        expect_v(32'h0000_0000);
        mtc0(5'd12, 32'h0);
        clr_exc();
        check("exc_vs_mtc0_status", bus.cp0_status_o);
        check("exc_vs_mtc0_epc", bus.cp0_epc_o);
        check("exc_vs_mtc0_cause", bus.cp0_cause_o);

        // Exception against an MTC0 Count in the same cycle
        set_exc(5'h0C, 32'h0000_0999, 1'b1, 1'b0, 32'h0);
        expect_v(32'h0000_0100);
        expect_v(32'h0000_0400);
        expect_v(32'h0000_0030);
        mtc0(5'd9, 32'h0000_0100);
        clr_exc();
        check("exc_vs_mtc0_count", bus.cp0_count_o);
        check("exc_exl_epc_hold", bus.cp0_epc_o);
        check("exc_exl_bd_hold", bus.cp0_cause_o);

        // ERET against an MTC0 EPC in the same cycle
        bus.eret_valid = 1'b1;
        expect_v(32'h0040_FF00);
        expect_v(32'h0000_0400);
        mtc0(5'd14, 32'h0000_DEAD);
        bus.eret_valid = 1'b0;
        check("eret_vs_mtc0_status", bus.cp0_status_o);
        check("eret_vs_mtc0_epc", bus.cp0_epc_o);
        expect_v(32'hCAFE_0000);
        mtc0(5'd14, 32'hCAFE_0000);
        check("mtc0_epc", bus.cp0_epc_o);

        // Count load and wrap
`ifdef CP0_COUNT_HALF_RATE_EN
        expect_v(32'd5);
        mtc0(5'd9, 32'd5);
        check("half_load5", bus.cp0_count_o);
        tick();
        expect_v(32'd5); check("half_hold5", bus.cp0_count_o);
        tick();
        expect_v(32'd6); check("half_inc6", bus.cp0_count_o);
        expect_v(32'hFFFF_FFFF);
        mtc0(5'd9, 32'hFFFF_FFFF);
        check("wrap_load", bus.cp0_count_o);
        tick();
        expect_v(32'hFFFF_FFFF); check("wrap_hold", bus.cp0_count_o);
        tick();
        expect_v(32'd0); check("wrap_to0", bus.cp0_count_o);
`else
        expect_v(32'hFFFF_FFFF);
        mtc0(5'd9, 32'hFFFF_FFFF);
        check("wrap_load", bus.cp0_count_o);
        tick();
        expect_v(32'd0); check("wrap_to0", bus.cp0_count_o);
        tick();
        expect_v(32'd1); check("wrap_to1", bus.cp0_count_o);
`endif

        // Cause write mask, read-only and unimplemented registers
        expect_v(32'h0000_0330);
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_wmask", bus.cp0_cause_o);
        expect_v(32'h0000_0030);
        mtc0(5'd13, 32'h0);
        check("cause_sw_clear", bus.cp0_cause_o);
        mtc0(5'd8, 32'h0000_5555);
        read_reg(5'd8, rd);
        expect_v(32'h3); check("badvaddr_ro", rd);
        mtc0(5'd16, 32'h0);
        read_reg(5'd16, rd);
        expect_v(32'h8000_0082); check("config0_ro", rd);
        read_reg(5'd10, rd);
        expect_v(32'h0); check("rd_unimpl", rd);
        read_reg(5'd12, rd);
        expect_v(32'h0040_FF00); check("rd_status", rd);

        // Hardware interrupt line
        expect_v(32'h0040_0401);
        mtc0(5'd12, 32'h0000_0401);
        check("status_im2_ie", bus.cp0_status_o);
        bus.int_i = 6'h01;
        tick();
        expect_v(32'h04); check("ip2_set", {24'd0, bus.cp0_cause_o[15:8]});
        expect_v(32'd0);  check("hw_int_req_lat", {31'd0, bus.int_req_o});
        tick();
        expect_v(32'd1);  check("hw_int_req_on", {31'd0, bus.int_req_o});

        // Asynchronous reset in mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        expect_v(32'd0);         check("arst_count", bus.cp0_count_o);
        expect_v(32'h0040_0000); check("arst_status", bus.cp0_status_o);
        expect_v(32'd0);         check("arst_epc", bus.cp0_epc_o);
        expect_v(32'd0);         check("arst_int_req", {31'd0, bus.int_req_o});
        bus.int_i = 6'h00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL leftover_expect observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total simulated time.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Architectural CP0 register file. It is the write-side owner of the state that the CP0 read-forwarding logic samples.
- Accepts MTC0 commits from WB, exception entry and ERET from the exception unit, and six hardware interrupt lines.
- Maintains the Count/Compare timer and presents raw register values plus an interrupt request to the pipeline.
- Sits beside the register file; its raw outputs feed the read-forwarding path in MEM.

Parameters:
- CONFIG0_VAL, 32'h8000_0082, read-only value of Config0 (reg 16).
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_cp0_write_en  in  1  MTC0 commit
- wb_cp0_write_addr  in  5  target register number
- wb_cp0_write_data  in  32  write data
- cp0_read_addr  in  5  raw read address
- cp0_read_data_o  out  32  raw read data, combinational, 0 for unimplemented numbers
- int_i  in  6  hardware interrupt lines, level-sensitive
- exc_valid  in  1  exception entry this cycle
- exc_code  in  5  ExcCode
- exc_epc  in  32  faulting PC
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badvaddr_en  in  1  load BadVAddr
- exc_badvaddr  in  32  faulting address
- eret_valid  in  1  ERET commit
- cp0_count_o, cp0_status_o, cp0_cause_o, cp0_epc_o, cp0_config0_o  out  32 each  current register values
- int_req_o  out  1  interrupt request to the exception unit

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All state is clocked on the rising edge of clk.
- Reset values:
  - Count=0, Compare=0, Status=STATUS_RST, Cause=0, EPC=0, BadVAddr=0.
  - The half-rate phase bit is 0.
  - int_req_o=0.
  - Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Implemented registers: 8 BadVAddr (read-only to MTC0), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 16 Config0 (constant).
- Writable masks:
  - Status: only IM[15:8], EXL[1], IE[0] are MTC0-writable; all other bits hold.
  - Cause: only IP[9:8] (software interrupts) are MTC0-writable.
  - Writes to 8, 16 or unimplemented numbers are ignored.
- Cause hardware fields, updated every cycle:
  - Cause.IP[15:10] <= int_i[5:0], with IP[15] ORed with Cause.TI.
  - Cause.TI[30] sets when Count==Compare (pre-update values) and holds until a Compare write.
  - A Compare write in the same cycle as a match clears TI; the write wins.
- Count:
  - Increments by 1 every cycle (see Optional Feature) and wraps from 32'hFFFF_FFFF to 0.
  - An MTC0 to Count loads the written value that cycle, with no increment.
- Priority when events coincide in one cycle: exc_valid > eret_valid > MTC0. A lower-priority Status/Cause/EPC update is dropped.
  - The MTC0 to Count/Compare still proceeds, since exceptions do not touch those registers.
- Exception entry (exc_valid=1):
  - Cause.ExcCode[6:2] <= exc_code.
  - If Status.EXL==0: EPC <= exc_epc, Cause.BD <= exc_bd.
  - If EXL was already 1: EPC and BD hold.
  - Status.EXL <= 1.
  - If exc_badvaddr_en: BadVAddr <= exc_badvaddr.
- ERET: Status.EXL <= 0.
- int_req_o is registered, 1-cycle latency: int_req_o <= Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]), using current register values.
- Outputs:
  - All cp0_*_o reflect the register value in the cycle after the write. No internal bypass; forwarding is done downstream.
  - cp0_read_data_o is a combinational mux on cp0_read_addr.

Optional Feature:
- Macro: CP0_COUNT_HALF_RATE_EN.
- Defined:
  - Count increments only when the phase bit is 1. The phase toggles every cycle.
  - An MTC0 to Count also clears the phase, so the first increment comes 2 cycles after the write.
- Undefined: Count increments every cycle and no phase bit exists.

Test Plan:
- Reset, then release → Status=32'h0040_0000, Count=1 after the 1st edge (full rate) and Config0=32'h8000_0082.
- MTC0 Compare=5, Count=0 → TI=1 and Cause[15]=1 at the edge where Count 5→6. With Status=32'h0000_8001, int_req_o=1 one cycle later. MTC0 Compare=100 → TI clears the next cycle.
- exc_valid with code 5'h04, epc 32'hBFC0_0100, bd=1, badvaddr 32'h0000_0003 → EPC=BFC0_0100, Cause[31]=1, Cause[6:2]=4, EXL=1, BadVAddr=3. A second exception with epc 32'h1234 → EPC unchanged and ExcCode updated.
- exc_valid and MTC0 Status=0 in the same cycle → EXL=1 and IM unchanged. eret_valid then clears EXL.
- MTC0 Count=32'hFFFF_FFFF → next cycle 0, following cycle 1 (wrap). With CP0_COUNT_HALF_RATE_EN, Count=5 is written, holds 2 cycles, then reads 6.
- MTC0 Cause=32'hFFFF_FFFF → only bits [9:8] change. Write to reg 8 → BadVAddr unchanged.
